// File: rtl/mem_rmw_ctrl.sv
// Single-access sequencer between the memory stage and a word-organised single-port RAM.
// Byte/halfword stores use read-modify-write. Optional MISALIGN_TRAP_EN makes misaligned
// accesses skip the memory and respond with an error.
module mem_rmw_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            mem_type_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [1:0] TYPE_BYTE = 2'b01;
    localparam logic [1:0] TYPE_HALF = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        MRG  = 3'd3,
        RESP = 3'd4
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [1:0]            mem_type;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t state;
    state_t state_nxt;
    req_t   req_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic   accept_c;
    logic   word_c;
    logic   trap_c;

    // Types 00 and 11 are both full-word accesses.
    function automatic logic is_word(input logic [1:0] mem_type);
        return mem_type[1] == mem_type[0];
    endfunction

    // Insert the right-aligned store lane into the old word at the addressed position.
    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_data,
        input logic [1:0]            mem_type,
        input logic [1:0]            offset
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        if (mem_type == TYPE_BYTE) begin
            case (offset)
                2'd0:    merged[7:0]   = new_data[7:0];
                2'd1:    merged[15:8]  = new_data[7:0];
                2'd2:    merged[23:16] = new_data[7:0];
                default: merged[31:24] = new_data[7:0];
            endcase
        end else if (mem_type == TYPE_HALF) begin
            if (offset[1]) begin
                merged[31:16] = new_data[15:0];
            end else begin
                merged[15:0]  = new_data[15:0];
            end
        end else begin
            merged = new_data;
        end
        return merged;
    endfunction

    assign accept_c = req_valid_i && (state == IDLE);
    assign word_c   = is_word(mem_type_i);

`ifdef MISALIGN_TRAP_EN
    logic misalign_c;
    logic err_q;

    assign misalign_c = (mem_type_i == TYPE_HALF) ? addr_i[0]
                      : (word_c ? (addr_i[1:0] != 2'b00) : 1'b0);
    assign trap_c     = misalign_c;

    // Error flag travels with the request and is presented only in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept_c) begin
            err_q <= misalign_c;
        end
    end

    assign rsp_err_o = err_q && (state == RESP);
`else
    assign trap_c    = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields are captured on accept so the core may drop them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else if (accept_c) begin
            req_q.we       <= req_we_i;
            req_q.mem_type <= mem_type_i;
            req_q.addr     <= addr_i;
            req_q.wdata    <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if ((state == MRG) && !req_q.we) begin
            rdata_q <= mem_rdata_i;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;

        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (trap_c) begin
                        state_nxt = RESP;
                    end else if (req_we_i && word_c) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            WR: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_wdata_o = req_q.wdata;
                state_nxt   = RESP;
            end
            RD: begin
                mem_en_o  = 1'b1;
                state_nxt = MRG;
            end
            MRG: begin
                if (req_q.we) begin
                    mem_en_o    = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_wdata_o = merge_word(mem_rdata_i, req_q.wdata,
                                             req_q.mem_type, req_q.addr[1:0]);
                end
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Word address is driven only while the memory is being accessed.
    assign mem_addr_o  = mem_en_o ? {req_q.addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Self-checking bench for mem_rmw_ctrl: word-array memory model plus a request-level
// reference of memory contents, latency and access counts.
module tb_mem_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  mem_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];
    logic [31:0] last_rdata;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_rmw_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .mem_type_i  (mem_type),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Synchronous single-port RAM, 16 words starting at byte address 0x100.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[5:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // One complete request, checked against the reference model.
    task automatic xact(input logic we, input logic [1:0] ty, input logic [31:0] a,
                        input logic [31:0] wd);
        int   idx  = int'(a[5:2]);
        int   off  = int'(a[1:0]);
        logic word = (ty[1] == ty[0]);
        logic mis  = (ty == 2'b10) ? a[0] : (word ? (a[1:0] != 2'b00) : 1'b0);
        logic trap;
        int   want_lat, want_rd, want_wr;
        int   lat = 0, rd = 0, wr = 0;
        logic addr_bad = 1'b0;
        logic err = 1'b0;
        logic [31:0] rdat = '0;
`ifdef MISALIGN_TRAP_EN
        trap = mis;
`else
        trap = 1'b0;
`endif
        if (trap) begin
            want_lat = 1; want_rd = 0; want_wr = 0;
        end else if (we && word) begin
            want_lat = 2; want_rd = 0; want_wr = 1;
        end else begin
            want_lat = 3; want_rd = 1; want_wr = we ? 1 : 0;
        end
        if (!trap) begin
            if (!we)              last_rdata = ref_mem[idx];
            else if (word)        ref_mem[idx] = wd;
            else if (ty == 2'b01) ref_mem[idx][8*off +: 8] = wd[7:0];
            else                  ref_mem[idx][16*(off/2) +: 16] = wd[15:0];
        end

        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; mem_type = ty; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); mem_type = 2'($urandom);
        addr = $urandom; wdata = $urandom;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (mem_en) begin
                if (mem_we) wr++;
                else        rd++;
                if (mem_addr !== {a[31:2], 2'b00}) addr_bad = 1'b1;
            end
            if (rsp_valid) begin
                err  = rsp_err;
                rdat = rsp_rdata;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(want_lat));
        chk("reads", 32'(rd), 32'(want_rd));
        chk("writes", 32'(wr), 32'(want_wr));
        chk("rsp_err", 32'(err), 32'(trap));
        chk("rsp_rdata", rdat, last_rdata);
        chk("mem_addr_bad", 32'(addr_bad), 32'd0);
        chk("mem_word", mem[idx], ref_mem[idx]);
        @(negedge clk);
        chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int rdy_at[$];
        int rsp_cnt;
        int gap;
        logic we_seen;
        logic rsp_seen;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; mem_type = 2'b00;
        addr = '0; wdata = '0; last_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Fill memory through word stores; word 0x100 gets the directed pattern.
        for (int i = 0; i < 16; i++)
            xact(1'b1, 2'b00, 32'h100 + 32'(4*i), (i == 0) ? 32'hAABBCCDD : $urandom);

        xact(1'b1, 2'b01, 32'h102, 32'h0000_0011);
        chk("byte_store_0x102", mem[0], 32'hAA11CCDD);
        xact(1'b1, 2'b00, 32'h100, 32'hAABBCCDD);
        xact(1'b1, 2'b10, 32'h102, 32'h0000_1234);
        chk("half_store_0x102", mem[0], 32'h1234CCDD);
        xact(1'b1, 2'b00, 32'h100, 32'hAABBCCDD);
        xact(1'b1, 2'b10, 32'h100, 32'h0000_1234);
        chk("half_store_0x100", mem[0], 32'hAABB1234);
        xact(1'b1, 2'b00, 32'h100, 32'hDEADBEEF);
        chk("word_store_0x100", mem[0], 32'hDEADBEEF);
        xact(1'b1, 2'b00, 32'h100, 32'hAABBCCDD);

        // Load held valid: second accept must land the cycle after RESP.
        rsp_cnt = 0; we_seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; mem_type = 2'b01; addr = 32'h103; wdata = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready) rdy_at.push_back(i);
            if (mem_we) we_seen = 1'b1;
            if (rsp_valid) begin
                rsp_cnt++;
                chk("b2b_rdata", rsp_rdata, 32'hAABBCCDD);
            end
            if (i == 7) req_valid = 1'b0;
        end
        gap = (rdy_at.size() >= 2) ? (rdy_at[1] - rdy_at[0]) : -1;
        chk("b2b_ready_count", 32'(rdy_at.size()), 32'd2);
        chk("b2b_accept_gap", 32'(gap), 32'd4);
        chk("b2b_rsp_count", 32'(rsp_cnt), 32'd2);
        chk("b2b_no_write", 32'(we_seen), 32'd0);
        last_rdata = 32'hAABBCCDD;

        // Reset during the merge cycle of a byte store aborts the write.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; mem_type = 2'b01; addr = 32'h102; wdata = 32'h11;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("abort_ready_hold", 32'(req_ready), 32'd1);
        rst = 1'b0;
        rsp_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen = 1'b1;
        end
        chk("abort_no_rsp", 32'(rsp_seen), 32'd0);
        chk("abort_mem_kept", mem[0], 32'hAABBCCDD);
        chk("abort_rdata_clr", rsp_rdata, 32'd0);
        last_rdata = '0;

        // Misaligned halfword store: trapped or merged depending on the build.
        xact(1'b1, 2'b10, 32'h101, 32'h0000_1234);
`ifdef MISALIGN_TRAP_EN
        chk("misalign_half", mem[0], 32'hAABBCCDD);
`else
        chk("misalign_half", mem[0], 32'hAABB1234);
`endif

        for (int n = 0; n < 60; n++)
            xact(1'($urandom), 2'($urandom), 32'h100 + 32'($urandom_range(0, 63)), $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_rmw_ctrl.md
# mem_rmw_ctrl

Sequencer between the core's memory stage and the single-port, word-organised data memory. It serialises one access at a time. It performs read-modify-write for byte and halfword stores, merging the new lane into the old word, and issues word stores as a single write. Loads return the raw aligned word for the downstream load-extract logic.

## Interface
- ADDR_WIDTH, 32, byte address width; data path fixed at 32 bits.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  controller can accept; request accepted when req_valid_i && req_ready_o
- req_we_i  in  1  1 = store, 0 = load
- mem_type_i  in  2  01 byte, 10 halfword, 00/11 word
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  32  aligned memory word (loads); holds last value otherwise
- rsp_err_o  out  1  misalignment error, valid with rsp_valid_o
- mem_en_o  out  1  memory access this cycle
- mem_we_o  out  1  write strobe (only with mem_en_o)
- mem_addr_o  out  ADDR_WIDTH  word address, bits [1:0] forced 0
- mem_wdata_o  out  32  full word to write
- mem_rdata_i  in  32  read data, valid the cycle after a read (mem_en_o=1, mem_we_o=0)

## Operation
- States: IDLE, WR, RD, MRG, RESP.
- IDLE: req_ready_o=1; on accept, latch we, type, addr, wdata.
  - Word store goes to WR.
  - Byte/half store and all loads go to RD.
- WR: mem_en_o=1, mem_we_o=1, mem_wdata_o=latched wdata; goes to RESP.
- RD: mem_en_o=1, mem_we_o=0; goes to MRG.
- MRG:
  - Store: mem_en_o=1, mem_we_o=1, mem_wdata_o = merge(mem_rdata_i, wdata, addr[1:0]).
  - Load: capture mem_rdata_i into rsp_rdata_o, no memory access.
  - Goes to RESP.
- RESP: rsp_valid_o=1 for exactly this cycle; goes to IDLE.
- Merge, byte: offset 0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24] take wdata[7:0]; other lanes keep old data.
- Merge, half: addr[1]=0→[15:0], addr[1]=1→[31:16] take wdata[15:0]; addr[0] is ignored.
- mem_en_o, mem_we_o and mem_wdata_o are 0 in IDLE and RESP.
- mem_addr_o = {latched addr[ADDR_WIDTH-1:2], 2'b00} whenever mem_en_o=1.
- req_valid_i is ignored outside IDLE. Request inputs need not be held after accept.

## Timing
- Reset values:
  - state IDLE, so req_ready_o=1.
  - rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
  - mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Accept in cycle T. Word store: write at T+1, rsp_valid_o at T+2.
- Sub-word store or load: read at T+1, write/capture at T+2, rsp_valid_o at T+3.
- Next accept is earliest the cycle after RESP. Throughput: one word store per 3 cycles, one RMW or load per 4 cycles.
- Reset mid-operation aborts immediately with no further memory access.
  - Reset in RD or MRG means the merged write is never issued and memory is unchanged.
  - No rsp_valid_o is produced for the aborted request.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, is accepted but performs no memory access.
  - The controller goes IDLE→RESP with rsp_err_o=1, so rsp_valid_o appears at T+1.
  - Loads and stores behave identically under this rule.
- MISALIGN_TRAP_EN undefined:
  - Low address bits are ignored as described in Operation.
  - rsp_err_o is constant 0.

## Test plan
- Byte store, memory[0x100]=0xAABBCCDD, addr 0x102, wdata 0x00000011 → read 0x100 at T+1, write 0xAA11CCDD at T+2, rsp_valid_o at T+3.
- Half store, addr 0x102, wdata 0x00001234 → write 0x1234CCDD. Repeat at addr 0x100 with the original word → write 0xAABB1234.
- Word store, addr 0x100, wdata 0xDEADBEEF → single write at T+1 with no read cycle, rsp_valid_o at T+2.
- Load, addr 0x103 → mem_we_o never high, rsp_rdata_o=0xAABBCCDD with rsp_valid_o at T+3. req_valid_i held high through the whole sequence → second request accepted the cycle after RESP.
- Byte store in progress with rst asserted during MRG → no write strobe, memory still 0xAABBCCDD, req_ready_o=1 while reset is high.
- MISALIGN_TRAP_EN defined, half store at 0x101 → rsp_valid_o and rsp_err_o=1 at T+1, mem_en_o never high.
- MISALIGN_TRAP_EN undefined, same half store at 0x101 → write 0xAABB1234 (wdata 0x1234), rsp_err_o=0.
